// File: rtl/seq_adder_ctrl_pkg.sv
// rtl/seq_adder_ctrl_pkg.sv - shared types and sizing helpers for the sliced add/subtract controller
package seq_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int num_slices(input int width, input int slice);
        return width / slice;
    endfunction

    function automatic bit width_ok(input int width, input int slice);
        return (slice > 0) && (width >= slice) && ((width % slice) == 0);
    endfunction

    // A single-slice build still needs a 1-bit index register.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_adder_ctrl_adder_slice.sv
// rtl/seq_adder_ctrl_adder_slice.sv - combinational SLICE-bit ripple adder built from full-adder cells
module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [SLICE:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    // Carry into the top bit is only meaningful for signed overflow on the last slice.
    assign cout_o     = carry[SLICE];
    assign c_msb_in_o = carry[SLICE-1];

endmodule

// File: rtl/seq_adder_ctrl.sv
// rtl/seq_adder_ctrl.sv - multi-cycle wide add/subtract that time-shares one SLICE-bit adder
module seq_adder_ctrl
    import seq_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout,
    output logic             io_out_ovf,
    output logic             io_busy
);

    localparam int N  = num_slices(WIDTH, SLICE);
    localparam int IW = idx_bits(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    if (!width_ok(WIDTH, SLICE)) begin : g_bad_params
        $error("seq_adder_ctrl: WIDTH must be a non-zero multiple of SLICE");
    end

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_sl, b_sl, s_sl;
    logic             cout_sl, c_msb_sl;

    assign a_sl = a_q[idx_q*SLICE +: SLICE];
    assign b_sl = b_q[idx_q*SLICE +: SLICE];

    adder_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_i        (a_sl),
        .b_i        (b_sl),
        .cin_i      (carry_q),
        .sum_o      (s_sl),
        .cout_o     (cout_sl),
        .c_msb_in_o (c_msb_sl)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io_in_valid) begin
                    // Subtraction is A + ~B + ~borrow, so the borrow-in flips into a carry-in.
                    a_d     = io_in_a;
                    b_d     = io_in_sub ? ~io_in_b : io_in_b;
                    carry_d = io_in_cin ^ io_in_sub;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[idx_q*SLICE +: SLICE] = s_sl;
                carry_d = cout_sl;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = c_msb_sl ^ cout_sl;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (io_out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_in_ready  = (state_q == ST_IDLE);
    assign io_out_valid = (state_q == ST_DONE);
    assign io_busy      = (state_q != ST_IDLE);
    assign io_out_sum   = sum_q;
    assign io_out_cout  = carry_q;
    assign io_out_ovf   = ovf_q;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// tb/tb_seq_adder_ctrl.sv - self-checking bench for seq_adder_ctrl with an arithmetic reference model
module tb_seq_adder_ctrl;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [WIDTH-1:0] io_in_a = '0;
    logic [WIDTH-1:0] io_in_b = '0;
    logic             io_in_cin = 1'b0;
    logic             io_in_sub = 1'b0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_cout;
    logic             io_out_ovf;
    logic             io_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    seq_adder_ctrl #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_in_a      (io_in_a),
        .io_in_b      (io_in_b),
        .io_in_cin    (io_in_cin),
        .io_in_sub    (io_in_sub),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_out_sum   (io_out_sum),
        .io_out_cout  (io_out_cout),
        .io_out_ovf   (io_out_ovf),
        .io_busy      (io_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: plain integer add/subtract on the full operands.
    task automatic ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic cin, input logic sub,
                              output logic [WIDTH-1:0] s, output logic co, output logic ov);
        logic [WIDTH:0] t;
        if (!sub) begin
            t  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            s  = t[WIDTH-1:0];
            co = t[WIDTH];
            ov = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end else begin
            t  = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
            s  = t[WIDTH-1:0];
            co = ({1'b0, a} >= ({1'b0, b} + {{WIDTH{1'b0}}, cin}));
            ov = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        end
    endtask

    typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_e;
    mphase_e          m_phase = M_IDLE;
    int               m_left  = 0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_cout  = 1'b0;
    logic             m_ovf   = 1'b0;
    logic [WIDTH-1:0] p_sum;
    logic             p_cout, p_ovf;

    // Result is published N edges after acceptance and retired on the handshake edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = M_IDLE;
            m_left  = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (io_in_valid) begin
                    ref_result(io_in_a, io_in_b, io_in_cin, io_in_sub, p_sum, p_cout, p_ovf);
                    m_left  = N;
                    m_phase = M_BUSY;
                end
                M_BUSY: begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_phase = M_DONE;
                        m_sum   = p_sum;
                        m_cout  = p_cout;
                        m_ovf   = p_ovf;
                    end
                end
                M_DONE: if (io_out_ready) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    always @(negedge clock) begin
        check("in_ready", io_in_ready, m_phase == M_IDLE);
        check("out_valid", io_out_valid, m_phase == M_DONE);
        check("busy", io_busy, m_phase != M_IDLE);
        if (m_phase != M_BUSY) begin
            check("out_sum", io_out_sum, m_sum);
            check("out_cout", io_out_cout, m_cout);
            check("out_ovf", io_out_ovf, m_ovf);
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!io_in_ready && k < 50) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (!io_in_ready) check("in_ready_wait", 0, 1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input int hold);
        int lat;
        wait_ready();
        io_in_a = a; io_in_b = b; io_in_cin = cin; io_in_sub = sub;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        lat = 0;
        while (!io_out_valid && lat < 20) begin
            @(posedge clock);
            #1;
            lat++;
        end
        check("latency", lat, N);
        check("lit_sum", io_out_sum, es);
        check("lit_cout", io_out_cout, ec);
        check("lit_ovf", io_out_ovf, eo);
        for (int i = 0; i < hold; i++) begin
            io_in_valid = 1'($urandom);
            io_in_a     = WIDTH'($urandom);
            io_in_b     = WIDTH'($urandom);
            io_in_sub   = 1'($urandom);
            @(posedge clock);
            #1;
            check("bp_valid", io_out_valid, 1);
            check("bp_sum", io_out_sum, es);
            check("bp_in_ready", io_in_ready, 0);
        end
        io_in_valid  = 1'b0;
        io_out_ready = 1'b1;
        @(posedge clock);
        #1;
        io_out_ready = 1'b0;
        check("post_hs_ready", io_in_ready, 1);
        check("post_hs_valid", io_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        int  gap;
        bit  hs, done;
        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", io_in_ready, 1);
        check("rst_valid", io_out_valid, 0);
        check("rst_busy", io_busy, 0);
        check("rst_sum", io_out_sum, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 5);

        // Abort while the slice index is 2.
        wait_ready();
        io_in_a = 16'hAAAA; io_in_b = 16'h5555; io_in_cin = 1'b1; io_in_sub = 1'b0;
        io_in_valid = 1'b1;
        @(posedge clock);
        #1;
        io_in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("abort_valid", io_out_valid, 0);
        check("abort_busy", io_busy, 0);
        check("abort_sum", io_out_sum, 0);
        check("abort_ready", io_in_ready, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        for (int n = 0; n < 150; n++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clock);
                #1;
            end
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            case ($urandom_range(0, 5))
                0: ra = 16'hFFFF;
                1: rb = 16'h8000;
                2: ra = 16'h7FFF;
                default: ;
            endcase
            wait_ready();
            io_in_a = ra; io_in_b = rb;
            io_in_cin = 1'($urandom); io_in_sub = 1'($urandom);
            io_in_valid = 1'b1;
            @(posedge clock);
            #1;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                io_out_ready = 1'($urandom);
                io_in_valid  = 1'($urandom);
                io_in_a      = WIDTH'($urandom);
                io_in_b      = WIDTH'($urandom);
                hs = io_out_valid && io_out_ready;
                @(posedge clock);
                #1;
                if (hs) done = 1'b1;
            end
            io_in_valid  = 1'b0;
            io_out_ready = 1'b0;
            if (!done) check("hs_timeout", 0, 1);
        end

        repeat (3) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
